// File: rtl/loadable_4bit_up_counter.sv
// Presettable up-counter: each clock it loads data_in (clamped to MAX_VALUE) or increments, wrapping after MAX_VALUE.
// Optional build macro COUNTER_SATURATE_EN makes the counter hold at MAX_VALUE instead of wrapping.
module loadable_4bit_up_counter #(
    parameter int unsigned      WIDTH       = 4,
    parameter logic [WIDTH-1:0] MAX_VALUE   = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_next;

    // Terminal-count compare happens before the increment, so the add never needs a carry out.
    always_comb begin
        cnt_next = '0;
        if (load) begin
            cnt_next = (data_in > MAX_VALUE) ? MAX_VALUE : data_in;
        end else if (cnt < MAX_VALUE) begin
            cnt_next = cnt + 1'b1;
        end else begin
`ifdef COUNTER_SATURATE_EN
            cnt_next = MAX_VALUE;
`else
            cnt_next = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= RESET_VALUE;
        end else begin
            cnt <= cnt_next;
        end
    end

    assign data_out = cnt;

endmodule

// File: tb/tb_loadable_4bit_up_counter.sv
// Bench for loadable_4bit_up_counter: directed plan plus randomized load/reset traffic
// checked against an arithmetic reference model, on a default instance and a MAX_VALUE=9 instance.
module tb_loadable_4bit_up_counter;

    logic       clk;
    logic       rst;
    logic       load;
    logic [3:0] data_in;
    logic [3:0] q0;
    logic [3:0] q1;

    int unsigned n_checks;
    int unsigned n_fail;
    int unsigned m0;
    int unsigned m1;

    localparam int unsigned MAX0 = 15;
    localparam int unsigned MAX1 = 9;
    localparam int unsigned RV0  = 0;
    localparam int unsigned RV1  = 2;

    loadable_4bit_up_counter u_dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .data_in  (data_in),
        .data_out (q0)
    );

    loadable_4bit_up_counter #(
        .WIDTH       (4),
        .MAX_VALUE   (4'd9),
        .RESET_VALUE (4'd2)
    ) u_dut_m9 (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .data_in  (data_in),
        .data_out (q1)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: load clamps to the ceiling; otherwise count modulo (max+1), or stick at max when saturating.
    function automatic int unsigned model_next(int unsigned v, bit l, int unsigned d, int unsigned maxv);
        if (l) return (d > maxv) ? maxv : d;
`ifdef COUNTER_SATURATE_EN
        return (v >= maxv) ? maxv : v + 1;
`else
        return (v + 1) % (maxv + 1);
`endif
    endfunction

    // Drive inputs mid-cycle, then check after the following rising edge.
    task automatic drive(input bit l, input logic [3:0] d, input bit r);
        @(negedge clk);
        load    = l;
        data_in = d;
        rst     = r;
        if (!r) begin
            m0 = RV0;
            m1 = RV1;
            #1;
            check("async_rst", {28'd0, q0}, m0);
            check("async_rst_m9", {28'd0, q1}, m1);
        end
        @(posedge clk);
        if (rst) begin
            m0 = model_next(m0, load, data_in, MAX0);
            m1 = model_next(m1, load, data_in, MAX1);
        end
        #1;
        check("count", {28'd0, q0}, m0);
        check("count_m9", {28'd0, q1}, m1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        load     = 1'b0;
        data_in  = '0;
        m0       = RV0;
        m1       = RV1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {28'd0, q0}, 0);
        check("reset_state_m9", {28'd0, q1}, 2);

        // Count to 7, assert reset between edges, hold, release.
        repeat (7) drive(1'b0, 4'd0, 1'b1);
        check("count_to_7", {28'd0, q0}, 7);
        repeat (3) drive(1'b0, 4'd0, 1'b0);
        check("held_in_reset", {28'd0, q0}, 0);
        drive(1'b0, 4'd0, 1'b1);
        check("first_after_release", {28'd0, q0}, 1);
        repeat (2) drive(1'b0, 4'd0, 1'b1);
        check("third_after_release", {28'd0, q0}, 3);

        // Load then count.
        drive(1'b1, 4'd8, 1'b1);
        check("load_8", {28'd0, q0}, 8);
        drive(1'b0, 4'd0, 1'b1);
        drive(1'b0, 4'd0, 1'b1);
        check("after_load_10", {28'd0, q0}, 10);

        // Wrap / saturate at the top.
        drive(1'b1, 4'd14, 1'b1);
        drive(1'b0, 4'd0, 1'b1);
        check("top_15", {28'd0, q0}, 15);
        drive(1'b0, 4'd0, 1'b1);
`ifdef COUNTER_SATURATE_EN
        check("saturate_15", {28'd0, q0}, 15);
`else
        check("wrap_0", {28'd0, q0}, 0);
`endif

        // Reset beats load.
        repeat (2) drive(1'b1, 4'd5, 1'b0);
        check("reset_over_load", {28'd0, q0}, 0);
        drive(1'b1, 4'd5, 1'b1);
        check("load_after_release", {28'd0, q0}, 5);

        // Clamp on the MAX_VALUE=9 instance.
        drive(1'b1, 4'd12, 1'b1);
        check("clamp_9", {28'd0, q1}, 9);
        check("no_clamp_12", {28'd0, q0}, 12);
        drive(1'b0, 4'd0, 1'b1);
`ifdef COUNTER_SATURATE_EN
        check("clamp_then_hold", {28'd0, q1}, 9);
`else
        check("clamp_then_wrap", {28'd0, q1}, 0);
`endif

        // Continuous load.
        repeat (4) drive(1'b1, 4'd3, 1'b1);
        check("continuous_load", {28'd0, q0}, 3);
        drive(1'b0, 4'd0, 1'b1);
        check("resume_after_load", {28'd0, q0}, 4);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)), $urandom_range(0, 29) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
